// File: rtl/rv_fetch_decode.sv
// rv_fetch_decode: multi-cycle RV32 R-type fetch/decode controller driving a register-file/ALU datapath
module rv_fetch_decode #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                MAX_WAIT = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic [4:0]        read_reg_num1,
    output logic [4:0]        read_reg_num2,
    output logic [4:0]        write_reg,
    output logic [3:0]        alu_control,
    output logic              regwrite,
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic              illegal_instr,
    output logic              fetch_err
);
    localparam int CW = $clog2(MAX_WAIT + 2);

    typedef enum logic [2:0] {IDLE, FETCH, DECODE, WRITEBACK, HALT} state_t;

    state_t        state, state_d;
    logic [31:0]   instr;
    logic [CW-1:0] wait_cnt;
    logic [3:0]    alu_d;
    logic          funct_ok;
    logic          is_ecall;
    logic          r_ok;
    logic          timeout;

    assign is_ecall      = instr == 32'h0000_0073;
    assign r_ok          = instr[6:0] == 7'b0110011 && funct_ok;
    assign timeout       = wait_cnt == CW'(MAX_WAIT);
    assign imem_req      = state == FETCH;
    assign imem_addr     = pc;
    assign read_reg_num1 = instr[19:15];
    assign read_reg_num2 = instr[24:20];
    assign write_reg     = instr[11:7];
    assign alu_control   = r_ok ? alu_d : 4'b0000;
    assign regwrite      = state == WRITEBACK && write_reg != 5'd0;

    // Map {funct7,funct3} of the held instruction onto the ALU operation code
    always_comb begin
        alu_d    = 4'b0000;
        funct_ok = 1'b1;
        case ({instr[31:25], instr[14:12]})
            10'b0000000_000: alu_d = 4'b0010;
            10'b0100000_000: alu_d = 4'b0100;
            10'b0000000_111: alu_d = 4'b0000;
            10'b0000000_110: alu_d = 4'b0001;
            10'b0000000_100: alu_d = 4'b0111;
            10'b0000000_001: alu_d = 4'b0011;
            10'b0000000_101: alu_d = 4'b0101;
            10'b0000000_010: alu_d = 4'b1000;
            default:         funct_ok = 1'b0;
        endcase
    end

    // Next-state selection; HALT is terminal until reset
    always_comb begin
        state_d = state;
        case (state)
            IDLE:      state_d = start ? FETCH : IDLE;
            FETCH:     state_d = imem_ack ? DECODE : (timeout ? HALT : FETCH);
            DECODE:    state_d = (is_ecall || !r_ok) ? HALT : WRITEBACK;
            WRITEBACK: state_d = FETCH;
            default:   state_d = HALT;
        endcase
    end

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_d;
    end

    // Instruction capture, fetch wait counter, sticky halt flags and PC advance
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc            <= RESET_PC;
            instr         <= '0;
            wait_cnt      <= '0;
            halted        <= 1'b0;
            illegal_instr <= 1'b0;
            fetch_err     <= 1'b0;
        end else begin
            wait_cnt <= (state == FETCH && !imem_ack) ? wait_cnt + 1'b1 : '0;
            if (state == FETCH && imem_ack) instr <= imem_rdata;
            if (state == FETCH && !imem_ack && timeout) fetch_err <= 1'b1;
            if (state == DECODE) begin
                halted        <= is_ecall;
                illegal_instr <= !is_ecall && !r_ok;
            end
            if (state == WRITEBACK) pc <= pc + ADDR_W'(4);
        end
    end
endmodule

// File: tb/tb_rv_fetch_decode.sv
// tb_rv_fetch_decode: directed self-checking bench for the fetch/decode controller
module tb_rv_fetch_decode;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [4:0]  read_reg_num1, read_reg_num2, write_reg;
    logic [3:0]  alu_control;
    logic        regwrite;
    logic [31:0] pc;
    logic        halted, illegal_instr, fetch_err;

    int n_vec = 0;
    int n_err = 0;
    int req_cycles;

    rv_fetch_decode dut (
        .clock(clock), .reset(reset), .start(start),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .read_reg_num1(read_reg_num1), .read_reg_num2(read_reg_num2),
        .write_reg(write_reg), .alu_control(alu_control), .regwrite(regwrite),
        .pc(pc), .halted(halted), .illegal_instr(illegal_instr), .fetch_err(fetch_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        start = 1'b0;
        imem_ack = 1'b0;
        step();
        reset = 1'b1;
        step();
    endtask

    task automatic fetch_one(input logic [31:0] word);
        imem_ack   = 1'b1;
        imem_rdata = word;
        step();
        imem_ack   = 1'b0;
    endtask

    initial begin
        step();
        step();
        chk("rst_pc", pc, 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_req", {31'b0, imem_req}, 32'h0);
        chk("rst_flags", {28'b0, regwrite, halted, illegal_instr, fetch_err}, 32'h0);
        chk("rst_regs", {13'b0, read_reg_num1, read_reg_num2, write_reg, alu_control}, 32'h0);
        reset = 1'b1;
        step();
        chk("idle_req", {31'b0, imem_req}, 32'h0);
        start = 1'b1;
        step();
        chk("fetch_req", {31'b0, imem_req}, 32'h1);
        reset = 1'b0;
        #1;
        chk("midrst_req", {31'b0, imem_req}, 32'h0);
        chk("midrst_pc", pc, 32'h0);
        start = 1'b0;
        step();
        reset = 1'b1;
        imem_ack = 1'b1;
        imem_rdata = 32'h0000_0073;
        step();
        imem_ack = 1'b0;
        chk("idle_ack_ignored_req", {31'b0, imem_req}, 32'h0);
        chk("idle_ack_ignored_flags", {29'b0, halted, illegal_instr, fetch_err}, 32'h0);
        step();
        chk("idle_hold_req", {31'b0, imem_req}, 32'h0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("add_fetch_req", {31'b0, imem_req}, 32'h1);
        chk("add_fetch_addr", imem_addr, 32'h0);
        chk("add_fetch_rw", {31'b0, regwrite}, 32'h0);
        fetch_one(32'h0020_81B3);
        chk("add_dec_rs1", {27'b0, read_reg_num1}, 32'd1);
        chk("add_dec_rs2", {27'b0, read_reg_num2}, 32'd2);
        chk("add_dec_rd", {27'b0, write_reg}, 32'd3);
        chk("add_dec_alu", {28'b0, alu_control}, 32'b0010);
        chk("add_dec_rw", {31'b0, regwrite}, 32'h0);
        chk("add_dec_req", {31'b0, imem_req}, 32'h0);
        step();
        chk("add_wb_rw", {31'b0, regwrite}, 32'h1);
        chk("add_wb_alu", {28'b0, alu_control}, 32'b0010);
        chk("add_wb_rd", {27'b0, write_reg}, 32'd3);
        chk("add_wb_pc", pc, 32'h0);
        step();
        chk("add_next_rw", {31'b0, regwrite}, 32'h0);
        chk("add_next_pc", pc, 32'h4);
        chk("add_next_addr", imem_addr, 32'h4);
        chk("add_next_req", {31'b0, imem_req}, 32'h1);
        fetch_one(32'h4073_02B3);
        chk("sub_dec_rs1", {27'b0, read_reg_num1}, 32'd6);
        chk("sub_dec_rs2", {27'b0, read_reg_num2}, 32'd7);
        chk("sub_dec_rd", {27'b0, write_reg}, 32'd5);
        chk("sub_dec_alu", {28'b0, alu_control}, 32'b0100);
        chk("sub_dec_rw", {31'b0, regwrite}, 32'h0);
        step();
        chk("sub_wb_rw", {31'b0, regwrite}, 32'h1);
        step();
        chk("sub_next_rw", {31'b0, regwrite}, 32'h0);
        chk("sub_next_pc", pc, 32'h8);
        fetch_one(32'h0020_8033);
        chk("x0_dec_alu", {28'b0, alu_control}, 32'b0010);
        step();
        chk("x0_wb_rw", {31'b0, regwrite}, 32'h0);
        step();
        chk("x0_next_pc", pc, 32'hC);
        chk("x0_next_addr", imem_addr, 32'hC);
        fetch_one(32'h0000_0013);
        chk("addi_dec_rw", {31'b0, regwrite}, 32'h0);
        step();
        chk("addi_halt_ill", {31'b0, illegal_instr}, 32'h1);
        chk("addi_halt_hlt", {31'b0, halted}, 32'h0);
        chk("addi_halt_pc", pc, 32'hC);
        chk("addi_halt_req", {31'b0, imem_req}, 32'h0);
        start = 1'b1;
        step();
        step();
        start = 1'b0;
        chk("addi_hold_req", {31'b0, imem_req}, 32'h0);
        chk("addi_hold_ill", {31'b0, illegal_instr}, 32'h1);
        chk("addi_hold_pc", pc, 32'hC);
        do_reset();
        chk("rst2_pc", pc, 32'h0);
        chk("rst2_ill", {31'b0, illegal_instr}, 32'h0);
        start = 1'b1;
        step();
        start = 1'b0;
        fetch_one(32'h0000_0073);
        step();
        chk("ecall_hlt", {31'b0, halted}, 32'h1);
        chk("ecall_ill", {31'b0, illegal_instr}, 32'h0);
        chk("ecall_ferr", {31'b0, fetch_err}, 32'h0);
        chk("ecall_req", {31'b0, imem_req}, 32'h0);
        chk("ecall_pc", pc, 32'h0);
        do_reset();
        start = 1'b1;
        step();
        start = 1'b0;
        req_cycles = 0;
        for (int i = 0; i < 40 && imem_req; i++) begin
            req_cycles++;
            step();
        end
        chk("to_req_cycles", req_cycles, 32'd16);
        chk("to_ferr", {31'b0, fetch_err}, 32'h1);
        chk("to_req", {31'b0, imem_req}, 32'h0);
        chk("to_hlt", {30'b0, halted, illegal_instr}, 32'h0);
        step();
        step();
        chk("to_hold_req", {31'b0, imem_req}, 32'h0);
        chk("to_hold_ferr", {31'b0, fetch_err}, 32'h1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/rv_fetch_decode.md
Name: rv_fetch_decode

Overview:
- Multi-cycle fetch/decode controller that sits directly upstream of the register-file/ALU datapath.
- Fetches 32-bit instructions from an instruction memory over a req/ack handshake and decodes RV32 R-type instructions.
- Drives the datapath's register-number, ALU-control and regwrite inputs with correct timing.
- Advances the PC, and halts on ECALL, on an illegal instruction, or on a fetch timeout.

Parameters:
- ADDR_W, 32, width of PC and instruction-memory address.
- RESET_PC, 0, PC value loaded on reset.
- MAX_WAIT, 15, maximum cycles FETCH waits for imem_ack before a fetch error.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  level; leaves IDLE when high.
- imem_req  out  1  fetch request.
- imem_addr  out  ADDR_W  fetch address; equals pc.
- imem_ack  in  1  one-cycle pulse; imem_rdata valid in that cycle.
- imem_rdata  in  32  fetched instruction.
- read_reg_num1  out  5  rs1 to the datapath.
- read_reg_num2  out  5  rs2 to the datapath.
- write_reg  out  5  rd to the datapath.
- alu_control  out  4  ALU operation code.
- regwrite  out  1  register-file write enable.
- pc  out  ADDR_W  current PC.
- halted  out  1  ECALL reached.
- illegal_instr  out  1  unsupported encoding fetched.
- fetch_err  out  1  imem_ack timeout.

Behaviour:
- States: IDLE, FETCH, DECODE, WRITEBACK, HALT (encoding free).
- Reset (asynchronous, reset=0):
  - state=IDLE, pc=RESET_PC, instruction register=0.
  - All outputs 0 except imem_addr=pc=RESET_PC.
  - Reset overrides every state, including mid-fetch; an in-flight ack after reset deasserts is ignored unless the FSM is in FETCH.
- IDLE:
  - start=1 -> FETCH next cycle; otherwise stay in IDLE.
- FETCH:
  - imem_req=1 for every cycle spent in FETCH; wait counter increments each cycle.
  - imem_ack=1 -> latch imem_rdata, clear counter, go to DECODE.
  - Counter reaching MAX_WAIT with no ack -> fetch_err=1, go to HALT. The timeout cycle is the (MAX_WAIT+1)th FETCH cycle.
- DECODE (one cycle, regwrite=0):
  - Register fields latched: read_reg_num1=instr[19:15], read_reg_num2=instr[24:20], write_reg=instr[11:7].
  - opcode=instr[6:0], funct3=instr[14:12], funct7=instr[31:25].
  - instr==32'h00000073 -> halted=1, go to HALT.
  - opcode 0110011 with a supported {funct7,funct3} -> alu_control latched, go to WRITEBACK.
  - Anything else -> illegal_instr=1, go to HALT; pc is not advanced.
- alu_control mapping ({funct7,funct3}):
  - ADD {0000000,000}=0010; SUB {0100000,000}=0100
  - AND {0000000,111}=0000; OR {0000000,110}=0001; XOR {0000000,100}=0111
  - SLL {0000000,001}=0011; SRL {0000000,101}=0101; SLT {0000000,010}=1000
- WRITEBACK (one cycle):
  - regwrite=1 unless write_reg==0; rd=x0 is never written.
  - read_reg_num1/2, write_reg and alu_control are held stable from DECODE through WRITEBACK, so the combinational datapath result is valid at the write edge.
  - pc <= pc+4, modulo 2^ADDR_W; wrap to 0 is silent.
  - Next state FETCH; start is not re-sampled.
- Latency: one R-type instruction = 1 FETCH cycle (if ack comes immediately) + DECODE + WRITEBACK = 3 cycles minimum.
- HALT:
  - Terminal; only reset exits.
  - halted/illegal_instr/fetch_err hold their values; regwrite=0, imem_req=0.
- regwrite is a single-cycle pulse and is never asserted outside WRITEBACK.

Test Plan:
- Reset mid-FETCH (imem_req=1, reset pulsed low) -> next cycle state IDLE, pc=RESET_PC, imem_req=0, all flags 0.
- start=1, ack immediate with 32'h002081B3 (add x3,x1,x2):
  - read_reg_num1=1, read_reg_num2=2, write_reg=3, alu_control=0010.
  - regwrite=1 exactly on cycle 3; pc 0->4; next imem_addr=4.
- 32'h407302B3 (sub x5,x6,x7) -> rs1=6, rs2=7, rd=5, alu_control=0100, single regwrite pulse.
- 32'h00208033 (add x0,x1,x2) -> alu_control=0010, regwrite stays 0, pc still advances by 4.
- 32'h00000013 (addi) -> illegal_instr=1 in HALT, pc unchanged, no further imem_req. 32'h00000073 -> halted=1, illegal_instr=0.
- imem_ack never asserted with MAX_WAIT=15 -> fetch_err=1 after 16 FETCH cycles, then HALT with imem_req=0.
